// File: rtl/ysyx_22050133_ifu_pkg.sv
// rtl/ysyx_22050133_ifu_pkg.sv - shared constants and state encoding for the instruction fetch unit
package ysyx_22050133_ifu_pkg;

    // PC loaded on reset; the first instruction is fetched from here.
    localparam logic [63:0] YSYX_22050133_RESET_PC = 64'h8000_0000;

    // addi x0,x0,0 - what decode substitutes for a squashed instruction.
    localparam logic [31:0] YSYX_22050133_INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        YSYX_22050133_IFU_IDLE = 2'b00,
        YSYX_22050133_IFU_REQ  = 2'b01,
        YSYX_22050133_IFU_WAIT = 2'b10,
        YSYX_22050133_IFU_HOLD = 2'b11
    } ifu_state_t;

endpackage

// File: rtl/ysyx_22050133_ifu.sv
// rtl/ysyx_22050133_ifu.sv - instruction fetch unit: PC register, fetch FSM and word select
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr     doubleword-aligned fetch request to instruction memory
//   rsp_valid/rsp_data               single-cycle fetch response (no backpressure)
//   inst_valid/inst_ready/inst/inst_pc  instruction and its PC to decode
//   redirect_valid/redirect_pc       PC redirect from execute (branch/jump/trap)
module ysyx_22050133_ifu
    import ysyx_22050133_ifu_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = YSYX_22050133_RESET_PC[XLEN-1:0]
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [63:0]     rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    ifu_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            load_inst;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] inst_pc_q;

    // Redirect targets are word aligned; the low two bits are discarded.
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        load_inst = 1'b0;

        case (state_q)
            YSYX_22050133_IFU_IDLE: begin
                state_d = YSYX_22050133_IFU_REQ;
            end
            YSYX_22050133_IFU_REQ: begin
                // A redirect coincident with acceptance still leaves the old
                // request outstanding, so its response must be dropped.
                if (req_ready) begin
                    state_d = YSYX_22050133_IFU_WAIT;
                    drop_d  = redirect_valid;
                end
            end
            YSYX_22050133_IFU_WAIT: begin
                if (rsp_valid) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect_valid) begin
                        state_d = YSYX_22050133_IFU_REQ;
                    end else begin
                        state_d   = YSYX_22050133_IFU_HOLD;
                        load_inst = 1'b1;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            YSYX_22050133_IFU_HOLD: begin
                if (redirect_valid || inst_ready) begin
                    state_d = YSYX_22050133_IFU_REQ;
                end
            end
            default: begin
                state_d = YSYX_22050133_IFU_IDLE;
            end
        endcase

        // Redirect outranks the sequential increment, even on a completed handshake.
        if (redirect_valid && (state_q != YSYX_22050133_IFU_IDLE)) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if ((state_q == YSYX_22050133_IFU_HOLD) && inst_ready) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= YSYX_22050133_IFU_IDLE;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if (load_inst) begin
                inst_q    <= pc_q[2] ? rsp_data[63:32] : rsp_data[31:0];
                inst_pc_q <= pc_q;
            end
        end
    end

    assign req_valid  = (state_q == YSYX_22050133_IFU_REQ);
    assign inst_valid = (state_q == YSYX_22050133_IFU_HOLD);
    assign req_addr   = {pc_q[XLEN-1:3], 3'b000};
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_ysyx_22050133_ifu.sv
// tb/tb_ysyx_22050133_ifu.sv - self-checking bench for the instruction fetch unit
module tb_ysyx_22050133_ifu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    always #5 clk = ~clk;

    ysyx_22050133_ifu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents, addressed by instruction (word) address.
    function automatic logic [31:0] word_at(input logic [63:0] pc);
        if (pc == 64'h8000_0000) return 32'h0000_0013;
        if (pc == 64'h8000_0004) return 32'h0010_0093;
        return pc[31:0] ^ pc[63:32] ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [63:0] mem_dword(input logic [63:0] a);
        logic [63:0] b;
        b = {a[63:3], 3'b000};
        return {word_at(b + 64'd4), word_at(b)};
    endfunction

    // Reference model in fetch-transaction terms.
    bit          model_on = 1'b0;
    bit          m_started, m_want_req, m_in_flight, m_stale, m_holding;
    logic [63:0] m_pc, m_inst_pc;
    logic [31:0] m_inst;
    int          delivered = 0;

    task automatic model_reset();
        m_started = 0; m_want_req = 0; m_in_flight = 0; m_stale = 0; m_holding = 0;
        m_pc = RST_PC; m_inst = 32'h0; m_inst_pc = RST_PC;
    endtask

    task automatic model_step();
        logic [63:0] tgt;
        tgt = {redirect_pc[63:2], 2'b00};
        if (!m_started) begin
            m_started  = 1;
            m_want_req = 1;
        end else if (m_want_req) begin
            if (req_ready) begin
                m_want_req  = 0;
                m_in_flight = 1;
                m_stale     = redirect_valid;
            end
            if (redirect_valid) m_pc = tgt;
        end else if (m_in_flight) begin
            if (rsp_valid) begin
                m_in_flight = 0;
                if (m_stale || redirect_valid) begin
                    m_stale    = 0;
                    m_want_req = 1;
                end else begin
                    m_holding = 1;
                    m_inst    = word_at(m_pc);
                    m_inst_pc = m_pc;
                    delivered++;
                end
            end else if (redirect_valid) begin
                m_stale = 1;
            end
            if (redirect_valid) m_pc = tgt;
        end else if (m_holding) begin
            if (redirect_valid) begin
                m_holding = 0; m_want_req = 1; m_pc = tgt;
            end else if (inst_ready) begin
                m_holding = 0; m_want_req = 1; m_pc = m_pc + 64'd4;
            end
        end
    endtask

    // Memory responder: samples the address on the handshake, replies after mem_delay cycles.
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    int          mem_delay = 1;
    logic [63:0] mem_addr;
    logic        rv_s = 1'b0;
    logic [63:0] ra_s = 64'h0;

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        if (rsp_valid) mem_busy = 0;
        if (rst_n && rv_s && req_ready) begin
            mem_busy = 1;
            mem_addr = ra_s;
            mem_cnt  = mem_delay - 1;
        end
        @(negedge clk);
        rv_s = req_valid;
        ra_s = req_addr;
        rsp_valid = 1'b0;
        rsp_data  = {$urandom, $urandom};
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_dword(mem_addr);
            end else begin
                mem_cnt--;
            end
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("req_valid", req_valid, m_want_req);
            chk("inst_valid", inst_valid, m_holding);
            if (m_want_req) chk("req_addr", req_addr, {m_pc[63:3], 3'b000});
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_inst_pc);
        end
    end

    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        if (mem_cnt > 1) mem_cnt = 1;
        #1;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_pc", inst_pc, RST_PC);
    endtask

    initial begin
        req_ready = 0; rsp_valid = 0; rsp_data = 0; inst_ready = 0;
        redirect_valid = 0; redirect_pc = 0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick(); tick();
        model_on = 1;
        chk("reset_req_valid", req_valid, 0);
        chk("reset_inst_valid", inst_valid, 0);
        chk("reset_inst", inst, 32'h0);
        chk("reset_inst_pc", inst_pc, RST_PC);

        // First fetch and latency
        req_ready = 1; rst_n = 1'b1;
        #1 chk("idle_req_valid", req_valid, 0);
        tick();
        chk("first_req_valid", req_valid, 1);
        chk("first_req_addr", req_addr, 64'h8000_0000);
        tick(); tick();
        chk("first_inst_valid", inst_valid, 1);
        chk("first_inst", inst, 32'h0000_0013);
        chk("first_inst_pc", inst_pc, 64'h8000_0000);

        // Consume; second instruction from the upper half of the same doubleword
        inst_ready = 1;
        tick();
        chk("second_req_addr", req_addr, 64'h8000_0000);
        tick(); tick();
        chk("second_inst", inst, 32'h0010_0093);
        chk("second_inst_pc", inst_pc, 64'h8000_0004);
        tick();
        chk("third_req_addr", req_addr, 64'h8000_0008);

        // Backpressure
        inst_ready = 0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_inst_valid", inst_valid, 1);
            chk("bp_req_valid", req_valid, 0);
            chk("bp_inst_pc", inst_pc, 64'h8000_0008);
        end
        inst_ready = 1;
        tick();
        chk("bp_next_req_addr", req_addr, 64'h8000_0008);

        // Redirect in WAIT, response one cycle later is dropped
        mem_delay = 2;
        tick();
        redirect_valid = 1; redirect_pc = 64'h8000_0100;
        tick();
        redirect_valid = 0; mem_delay = 1;
        tick();
        chk("drop_inst_valid", inst_valid, 0);
        chk("drop_req_addr", req_addr, 64'h8000_0100);
        tick(); tick();
        chk("redir_inst_pc", inst_pc, 64'h8000_0100);

        // Redirect coincident with the response
        tick(); tick();
        redirect_valid = 1; redirect_pc = 64'h8000_0206;
        tick();
        redirect_valid = 0;
        chk("coinc_inst_valid", inst_valid, 0);
        chk("coinc_req_addr", req_addr, 64'h8000_0200);
        tick(); tick();
        chk("coinc_inst_pc", inst_pc, 64'h8000_0204);

        // Redirect in HOLD with inst_ready high, then wrap of pc+4
        redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect_valid = 0;
        chk("wrap_req_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        tick(); tick();
        chk("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_next_req_addr", req_addr, 64'h0);

        // Reset mid-WAIT; late response lands after release
        mem_delay = 3;
        tick();
        async_reset();
        tick();
        rst_n = 1'b1; mem_delay = 1;
        tick();
        chk("post_rst_req_addr", req_addr, 64'h8000_0000);
        tick(); tick();
        chk("post_rst_inst", inst, 32'h0000_0013);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            req_ready      = ($urandom_range(0, 9) < 7);
            inst_ready     = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 15) == 0);
            mem_delay      = $urandom_range(1, 3);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 64'h8000_0000 + 64'($urandom_range(0, 255));
                1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: redirect_pc = {32'h0, $urandom};
            endcase
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        chk("random_deliveries", (delivered > 200), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22050133_ifu.md
Name: ysyx_22050133_ifu

Overview:
- Instruction fetch unit; it is the producer end of the decode stage's instruction input.
- Holds the PC and issues 64-bit-aligned fetch requests to instruction memory over a request/response handshake.
- Selects the 32-bit instruction word from each response and presents it with its PC to the decode stage over a valid/ready handshake.
- Accepts PC redirects from execute (branch/jump/trap) and squashes any stale fetch.

Parameters:
- RESET_PC, 64'h8000_0000, PC value loaded on reset.
- XLEN, 64, PC and address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  out  1  fetch request valid
- req_ready  in  1  memory accepts request
- req_addr  out  XLEN  fetch address, {pc[XLEN-1:3],3'b000}
- rsp_valid  in  1  fetch data returned (single cycle, no backpressure)
- rsp_data  in  64  aligned doubleword
- inst_valid  out  1  instruction valid to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word
- inst_pc  out  XLEN  PC of inst
- redirect_valid  in  1  PC redirect
- redirect_pc  in  XLEN  redirect target

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE, drop=0.
  - inst=32'h0, inst_pc=RESET_PC, inst_valid=0, req_valid=0.
- States are IDLE, REQ, WAIT, HOLD. All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- IDLE: lasts one cycle after reset release, then goes to REQ.
- REQ:
  - req_valid=1, req_addr from the current pc.
  - On req_ready: go to WAIT.
  - Memory samples req_addr only on the handshake, so req_addr may change while not accepted.
- WAIT:
  - On rsp_valid with drop=1: clear drop, go to REQ.
  - On rsp_valid with drop=0: inst <= pc[2] ? rsp_data[63:32] : rsp_data[31:0]; inst_pc <= pc; go to HOLD.
- HOLD:
  - inst_valid=1; inst and inst_pc stay stable while inst_ready=0.
  - On inst_ready: pc <= pc+4, go to REQ.
- Minimum latency:
  - Request accepted in cycle N, response in N+1 → inst_valid=1 in N+2.
  - Back-to-back instruction throughput is one per 3 cycles (no prefetch).
- Redirect (highest priority, any state except IDLE):
  - pc <= {redirect_pc[XLEN-1:2],2'b00}; low bits are forced to zero.
  - REQ, no req_ready: stay in REQ; the new address is presented next cycle.
  - REQ with req_ready in the same cycle: the old request counts as accepted; go to WAIT with drop=1.
  - WAIT, no rsp_valid: drop <= 1, stay in WAIT.
  - WAIT with rsp_valid in the same cycle: the response is discarded; drop stays 0; go to REQ.
  - HOLD: go to REQ; inst_valid=0 next cycle. If inst_ready is also high, the handshake counts as completed; downstream squashes it. pc takes redirect_pc, not pc+4.
- Boundaries:
  - pc addition wraps modulo 2^XLEN.
  - rsp_valid in REQ, IDLE or HOLD is ignored. The memory side guarantees this does not occur.
  - Reset asserted mid-WAIT: everything returns to reset values immediately; a late response arriving after reset release in IDLE/REQ is ignored.
- Only one request is outstanding at any time; drop is 1 only while in WAIT.

Decomposition:
- Shared package/defines header holds:
  - `ysyx_22050133_RESET_PC`
  - state encodings `ysyx_22050133_IFU_IDLE/REQ/WAIT/HOLD` (2-bit)
  - `ysyx_22050133_INST_NOP` (32'h00000013), for decode-side squash
- No sub-module: the PC register, FSM and word select live in one module.

Test Plan:
- Reset release with req_ready=1 → req_valid rises in cycle 2, req_addr=0x80000000; rsp_data=64'h00100093_00000013 next cycle → inst=0x00000013, inst_pc=0x80000000.
- Consume with inst_ready=1 → next req_addr=0x80000000 (pc=0x80000004) → inst=0x00100093, inst_pc=0x80000004; third req_addr=0x80000008.
- Backpressure: inst_ready=0 for 5 cycles → inst/inst_pc/inst_valid stable, req_valid=0; then inst_ready=1 → pc+4 fetched.
- Redirect in WAIT to 0x80000100, response next cycle → response dropped, inst_valid stays 0, next req_addr=0x80000100, delivered inst_pc=0x80000100.
- Redirect to 0x80000206 coincident with rsp_valid in WAIT → response discarded, next req_addr=0x80000200, inst_pc=0x80000204.
- rst_n pulsed low mid-WAIT → req_valid and inst_valid drop immediately; after release first req_addr=0x80000000.
